// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-master Avalon-MM arbiter onto one SDRAM port, M0 favoured with a bounded quota.
module sdram_port_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int M0_QUOTA    = 4,
  parameter int MAX_PENDING = 8,
  parameter int PEND_W      = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic [PEND_W-1:0]   pending,
  output logic                err_orphan
);
  localparam int PTR_W = MAX_PENDING > 1 ? $clog2(MAX_PENDING) : 1;
  localparam int RUN_W = $clog2(M0_QUOTA + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic [RUN_W-1:0] m0_run_q, m0_run_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MAX_PENDING-1:0] fifo_q, fifo_d;
  logic err_q, err_d;
  logic req0, req1, gnt, gnt_v, wr, acc, push, pop, head;
  always_comb begin
    req0 = m0_write | (m0_read & (pending_q < PEND_W'(MAX_PENDING)));
    req1 = m1_write | (m1_read & (pending_q < PEND_W'(MAX_PENDING)));
    gnt = state_q == LOCKED ? owner_q : req1 & (~req0 | (m0_run_q == RUN_W'(M0_QUOTA)));
    gnt_v = state_q == LOCKED ? (owner_q ? req1 : req0) : (req0 | req1);
    wr = gnt ? m1_write : m0_write;
    s_write = gnt_v & wr;
    s_read = gnt_v & ~wr;
    s_address = gnt_v ? (gnt ? m1_address : m0_address) : '0;
    s_writedata = gnt_v ? (gnt ? m1_writedata : m0_writedata) : '0;
    s_byteenable = gnt_v ? (gnt ? m1_byteenable : m0_byteenable) : '0;
    acc = gnt_v & ~s_waitrequest;
    m0_waitrequest = ~(acc & ~gnt);
    m1_waitrequest = ~(acc & gnt);
    state_d = (gnt_v & s_waitrequest) ? LOCKED : IDLE;
    owner_d = (gnt_v & s_waitrequest) ? gnt : owner_q;
    m0_run_d = (~m1_read & ~m1_write) | (acc & gnt) ? '0 :
               (acc & ~gnt & req1 & (m0_run_q < RUN_W'(M0_QUOTA))) ? m0_run_q + 1'b1 : m0_run_q;
    // Only a response with a read outstanding may pop; anything else is an orphan
    push = acc & s_read;
    pop = s_readdatavalid & (pending_q != '0);
    head = fifo_q[rd_ptr_q];
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = gnt;
    wr_ptr_d = push ? (wr_ptr_q == PTR_W'(MAX_PENDING - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q == PTR_W'(MAX_PENDING - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    pending_d = pending_q + PEND_W'(push) - PEND_W'(pop);
    err_d = err_q | (s_readdatavalid & (pending_q == '0));
    m0_readdatavalid = pop & ~head;
    m1_readdatavalid = pop & head;
    m0_readdata = s_readdata;
    m1_readdata = s_readdata;
    pending = pending_q;
    err_orphan = err_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      m0_run_q <= '0;
      pending_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fifo_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      m0_run_q <= m0_run_d;
      pending_q <= pending_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fifo_q <= fifo_d;
      err_q <= err_d;
    end
  end
endmodule
